cl_seq: RTL and testbench

- Parametrised, registered successor to the 1-bit logic cell.
- WIDTH-bit bitwise logic unit with the same four operations, selected by S.
- Adds an internal accumulator as an alternative A operand, result flags, and a valid/ready pipeline stage.
- Sits between the register-file operand path and the writeback path of the lab datapath.

---
 rtl/cl_pkg.sv | 18 +
 rtl/cl_vec.sv | 33 +++
 rtl/cl_seq.sv | 89 ++++++++
 tb/tb_cl_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// Shared definitions for the cl_seq bitwise logic unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cl_pkg;

   // Operation select codes, driven on S.
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   // Bit positions for a packed flag bus, should one be needed downstream.
   localparam int FLG_ZERO   = 0;
   localparam int FLG_ONES   = 1;
   localparam int FLG_PARITY = 2;
   localparam int FLG_W      = 3;

endpackage

// File: rtl/cl_vec.sv
// Purpose: WIDTH-bit bitwise logic, one replicated single-bit cell per bit.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
// Ports: a, b operands; s operation select; y result (a only for NOT).
module cl_vec
   import cl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] y
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic r;

      // Same four-way mux as the original 1-bit cell.
      always_comb begin
         r = 1'b0;
         case (s)
            OP_AND:  r = a[i] & b[i];
            OP_OR:   r = a[i] | b[i];
            OP_XOR:  r = a[i] ^ b[i];
            default: r = ~a[i];
         endcase
      end

      assign y[i] = r;
   end

endmodule

// File: rtl/cl_seq.sv
// Purpose: registered WIDTH-bit logic unit with accumulator operand, result flags and valid/ready.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a held result freezes out and flags.
// Ports: in_valid/in_ready request handshake; a, b, S, use_acc, wr_acc operation fields;
//        clr_acc handshake-independent accumulator clear; out_valid/out_ready result handshake;
//        out, zero, ones, parity registered result and flags; acc current accumulator.
module cl_seq
   import cl_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] ACC_RST = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       S,
   input  logic             use_acc,
   input  logic             wr_acc,
   input  logic             clr_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             ones,
   output logic             parity,
   output logic [WIDTH-1:0] acc
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] res;

   // Operand A comes from the accumulator's current (pre-update) value.
   assign opa = use_acc ? acc : a;

   cl_vec #(.WIDTH(WIDTH)) u_vec (
      .a (opa),
      .b (b),
      .s (S),
      .y (res)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= EMPTY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      out_valid = (state == FULL);
      in_ready  = (state == EMPTY) || out_ready;
      accept    = in_valid && in_ready;
      case (state)
         EMPTY:   if (accept) state_nxt = FULL;
         // A drained slot refilled in the same cycle stays FULL.
         FULL:    if (out_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Flags are computed from the value being loaded so they always match out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out    <= '0;
         zero   <= 1'b1;
         ones   <= 1'b0;
         parity <= 1'b0;
      end else if (accept) begin
         out    <= res;
         zero   <= (res == '0);
         ones   <= &res;
         parity <= ^res;
      end
   end

   // Clear wins over a same-cycle write; the result still goes to out.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               acc <= ACC_RST;
      else if (clr_acc)           acc <= ACC_RST;
      else if (accept && wr_acc)  acc <= res;
   end

endmodule

// File: tb/tb_cl_seq.sv
// Purpose: self-checking bench for cl_seq against a transaction-level model.
// Latency: n/a.
// Backpressure: exercised directed and with random out_ready.
module tb_cl_seq;

   localparam int         W       = 8;
   localparam logic [W-1:0] ACC_RST = '0;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid, in_ready;
   logic [W-1:0] a, b;
   logic [1:0]   S;
   logic         use_acc, wr_acc, clr_acc;
   logic         out_valid, out_ready;
   logic [W-1:0] out, acc;
   logic         zero, ones, parity;

   int checks   = 0;
   int failures = 0;

   // Model state: one result slot and the accumulator.
   logic         m_vld;
   logic [W-1:0] m_out;
   logic [W-1:0] m_acc;

   always #5 clk = ~clk;

   cl_seq #(.WIDTH(W), .ACC_RST(ACC_RST)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .S         (S),
      .use_acc   (use_acc),
      .wr_acc    (wr_acc),
      .clr_acc   (clr_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .ones      (ones),
      .parity    (parity),
      .acc       (acc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] op_f(input logic [1:0] s, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
      case (s)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~x;
      endcase
   endfunction

   task automatic check_outputs();
      logic [W-1:0] all1;
      all1 = '1;
      check("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
      check("out", {24'd0, out}, {24'd0, m_out});
      check("zero", {31'd0, zero}, {31'd0, m_out == 0});
      check("ones", {31'd0, ones}, {31'd0, m_out == all1});
      check("parity", {31'd0, parity}, {31'd0, ^m_out});
      check("acc", {24'd0, acc}, {24'd0, m_acc});
   endtask

   // Called 1ns after a rising edge with inputs already driven.
   task automatic cycle();
      logic         rdy, take;
      logic [W-1:0] res;
      #1;
      rdy  = !m_vld || out_ready;
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      take = in_valid && rdy;
      res  = op_f(S, use_acc ? m_acc : a, b);
      @(posedge clk);
      if (take)           begin m_out = res; m_vld = 1'b1; end
      else if (out_ready) m_vld = 1'b0;
      if (clr_acc)             m_acc = ACC_RST;
      else if (take && wr_acc) m_acc = res;
      #1;
      check_outputs();
   endtask

   task automatic req(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [1:0] s, input logic ua, input logic wa,
                      input logic ca, input logic ordy);
      in_valid = iv; a = av; b = bv; S = s;
      use_acc = ua; wr_acc = wa; clr_acc = ca; out_ready = ordy;
      cycle();
   endtask

   logic [W-1:0] ops_exp [4];
   logic [W-1:0] first_res;

   initial begin
      ops_exp[0] = 8'h30; ops_exp[1] = 8'hFC; ops_exp[2] = 8'hCC; ops_exp[3] = 8'h0F;
      reset_n = 1'b0;
      in_valid = 0; a = 0; b = 0; S = 0; use_acc = 0; wr_acc = 0; clr_acc = 0; out_ready = 0;
      m_vld = 0; m_out = '0; m_acc = ACC_RST;
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", {31'd0, in_ready}, 32'd1);

      // All four operations, free-flowing output.
      for (int i = 0; i < 4; i++) begin
         req(1, 8'hF0, 8'h3C, 2'(i), 0, 0, 0, 1);
         check("op_const", {24'd0, out}, {24'd0, ops_exp[i]});
         check("op_zero", {31'd0, zero}, 32'd0);
         check("op_par", {31'd0, parity}, 32'd0);
      end

      // Flag corners.
      req(1, 8'hA5, 8'hA5, 2'b10, 0, 0, 0, 1);
      check("xor_zero", {31'd0, zero}, 32'd1);
      check("xor_out", {24'd0, out}, 32'd0);
      req(1, 8'h00, 8'h5A, 2'b11, 0, 0, 0, 1);
      check("not_ones", {31'd0, ones}, 32'd1);
      check("not_out", {24'd0, out}, 32'hFF);
      req(0, 8'h00, 8'h00, 2'b00, 0, 0, 0, 1);

      // Backpressure: second request stalls until out_ready rises for a cycle.
      req(1, 8'h0F, 8'h33, 2'b00, 0, 0, 0, 0);
      first_res = out;
      check("bp_first", {24'd0, first_res}, 32'h03);
      req(1, 8'hF0, 8'h33, 2'b01, 0, 0, 0, 0);
      check("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
      check("bp_frozen", {24'd0, out}, 32'h03);
      req(1, 8'hF0, 8'h33, 2'b01, 0, 0, 0, 1);
      check("bp_second", {24'd0, out}, 32'hF3);
      check("bp_no_bubble", {31'd0, out_valid}, 32'd1);
      req(0, 8'h00, 8'h00, 2'b00, 0, 0, 0, 1);
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // Accumulator chain from zero.
      req(0, 8'h00, 8'h00, 2'b00, 0, 0, 1, 1);
      req(1, 8'h77, 8'h01, 2'b01, 1, 1, 0, 1);
      check("chain1_acc", {24'd0, acc}, 32'h01);
      req(1, 8'h77, 8'h03, 2'b10, 1, 1, 0, 1);
      check("chain2_acc", {24'd0, acc}, 32'h02);
      check("chain2_out", {24'd0, out}, 32'h02);

      // Clear beats a simultaneous write; result still reaches out.
      req(1, 8'h55, 8'hFF, 2'b00, 0, 1, 1, 1);
      check("clr_out", {24'd0, out}, 32'h55);
      check("clr_acc", {24'd0, acc}, {24'd0, ACC_RST});

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         req(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) != 0));
      end

      // Asynchronous reset while a result is held under backpressure.
      req(1, 8'h12, 8'h34, 2'b01, 0, 1, 0, 0);
      req(1, 8'h12, 8'h34, 2'b01, 0, 1, 0, 0);
      #2;
      reset_n = 1'b0;
      m_vld = 0; m_out = '0; m_acc = ACC_RST;
      #1;
      check_outputs();
      @(negedge clk);
      reset_n = 1'b1;
      in_valid = 0;
      #1;
      check("ready_post_async", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
